mod_bus_arb: RTL

Two-master arbiter that shares one memory-mapped module data port (de/daddr/drw/din/dout) between the CPU data port (master 0) and a secondary bus master such as a DMA or debug engine (master 1). It sits between the masters and the memory-mapped module address decoder. It grants one single-cycle access at a time with round-robin fairness and an optional bounded bus lock for read-modify-write sequences.

---
 rtl/bus_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 22 ++
 rtl/mod_bus_arb.sv | 132 +++++++++++++
 3 files changed

// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the two-master bus arbiter:
// drw bit positions, one-hot grant encodings and the lock counter width.
package bus_arb_pkg;

    localparam int DRW_WRITE_BIT = 0;
    localparam int DRW_READ_BIT  = 1;
    localparam int LCNT_W        = 4;

    typedef enum logic [1:0] {
        GNT_IDLE = 2'b00,
        GNT_M0   = 2'b01,
        GNT_M1   = 2'b10
    } gnt_e;

    // Map a master index to its one-hot grant.
    function automatic gnt_e gnt_for(input logic m);
        return m ? GNT_M1 : GNT_M0;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way round-robin picker.
// On a tie, the master that was not granted last wins.
module rr_pick2
    import bus_arb_pkg::*;
(
    input  logic [1:0] eligible_i,
    input  logic       last_i,
    output gnt_e       gnt_o
);

    // Resolve eligibility to a one-hot grant.
    always_comb begin
        gnt_o = GNT_IDLE;
        case (eligible_i)
            2'b01:   gnt_o = GNT_M0;
            2'b10:   gnt_o = GNT_M1;
            2'b11:   gnt_o = gnt_for(~last_i);
            default: gnt_o = GNT_IDLE;
        endcase
    end

endmodule

// File: rtl/mod_bus_arb.sv
// Two-master single-cycle bus arbiter with round-robin fairness.
// Define ARB_LOCK_EN to build the bounded bus-lock feature (MAX_LOCK grants).
module mod_bus_arb
    import bus_arb_pkg::*;
#(
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_lock,
    input  logic [31:0] m0_daddr,
    input  logic [1:0]  m0_drw,
    input  logic [31:0] m0_din,
    output logic        m0_ack,
    output logic [31:0] m0_dout,
    input  logic        m1_req,
    input  logic        m1_lock,
    input  logic [31:0] m1_daddr,
    input  logic [1:0]  m1_drw,
    input  logic [31:0] m1_din,
    output logic        m1_ack,
    output logic [31:0] m1_dout,
    output logic        s_de,
    output logic [31:0] s_daddr,
    output logic [1:0]  s_drw,
    output logic [31:0] s_din,
    input  logic [31:0] s_dout
);

    gnt_e       grant_q, grant_d, pick_s;
    logic       last_q, last_d;
    logic [1:0] elig_s;

    // A master just granted sits out one cycle so the other can get in.
    assign elig_s = {m1_req & ~grant_q[1], m0_req & ~grant_q[0]};

    rr_pick2 u_pick (
        .eligible_i (elig_s),
        .last_i     (last_q),
        .gnt_o      (pick_s)
    );

`ifdef ARB_LOCK_EN
    logic [LCNT_W-1:0] lcnt_q, lcnt_d;
    logic              run_ok_s, hold_s;

    assign run_ok_s = ({1'b0, lcnt_q} + 5'd1) < 5'(MAX_LOCK);

    // Lock override: current grantee keeps the bus while locked, requesting and under the limit.
    always_comb begin
        hold_s  = 1'b0;
        grant_d = pick_s;
        lcnt_d  = '0;
        case (grant_q)
            GNT_M0:  hold_s = m0_lock & m0_req & run_ok_s;
            GNT_M1:  hold_s = m1_lock & m1_req & run_ok_s;
            default: hold_s = 1'b0;
        endcase
        if (hold_s) begin
            grant_d = grant_q;
            lcnt_d  = lcnt_q + LCNT_W'(1);
        end else begin
            grant_d = pick_s;
            lcnt_d  = '0;
        end
    end

    // Lock run counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            lcnt_q <= '0;
        end else begin
            lcnt_q <= lcnt_d;
        end
    end
`else
    logic lock_unused_s;
    assign lock_unused_s = m0_lock ^ m1_lock;
    assign grant_d       = pick_s;
`endif

    // Pointer follows the new grantee and holds while idle.
    always_comb begin
        last_d = last_q;
        case (grant_d)
            GNT_M0:  last_d = 1'b0;
            GNT_M1:  last_d = 1'b1;
            default: last_d = last_q;
        endcase
    end

    // Grant and pointer registers; master 0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= GNT_IDLE;
            last_q  <= 1'b1;
        end else begin
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Slave mux driven only from the grant register; rst kills the enable at once.
    always_comb begin
        s_de    = 1'b0;
        s_daddr = 32'd0;
        s_drw   = 2'b00;
        s_din   = 32'd0;
        case (grant_q)
            GNT_M0: begin
                s_de    = ~rst;
                s_daddr = m0_daddr;
                s_drw   = m0_drw;
                s_din   = m0_din;
            end
            GNT_M1: begin
                s_de    = ~rst;
                s_daddr = m1_daddr;
                s_drw   = m1_drw;
                s_din   = m1_din;
            end
            default: s_de = 1'b0;
        endcase
    end

    assign m0_ack  = grant_q[0];
    assign m1_ack  = grant_q[1];
    assign m0_dout = grant_q[0] ? s_dout : 32'd0;
    assign m1_dout = grant_q[1] ? s_dout : 32'd0;

endmodule
